// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode 7-segment scan controller with a double-buffered frame, PWM dimming,
// blanking and leading-zero suppression. Define SEG_SCAN_DP_EN to add the decimal-point path.
module seg_scan_ctrl #(
    parameter int DIGITS = 8,
    parameter int DIV_W  = 15,
    parameter int PWM_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     blank_mask,
`ifdef SEG_SCAN_DP_EN
    input  logic [DIGITS-1:0]     dp_mask,
    output logic                  dp,
`endif
    input  logic                  load,
    input  logic                  lz_en,
    input  logic [PWM_W-1:0]      brightness,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done,
    output logic                  pending
);

    localparam int POS_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(DIGITS - 1);

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        case (v)
            4'h0:    hex_to_seg = 7'h40;
            4'h1:    hex_to_seg = 7'h79;
            4'h2:    hex_to_seg = 7'h24;
            4'h3:    hex_to_seg = 7'h30;
            4'h4:    hex_to_seg = 7'h19;
            4'h5:    hex_to_seg = 7'h12;
            4'h6:    hex_to_seg = 7'h02;
            4'h7:    hex_to_seg = 7'h78;
            4'h8:    hex_to_seg = 7'h00;
            4'h9:    hex_to_seg = 7'h10;
            4'hA:    hex_to_seg = 7'h08;
            4'hB:    hex_to_seg = 7'h03;
            4'hC:    hex_to_seg = 7'h46;
            4'hD:    hex_to_seg = 7'h21;
            4'hE:    hex_to_seg = 7'h06;
            default: hex_to_seg = 7'h0E;
        endcase
    endfunction

    logic [DIV_W-1:0]    tick;
    logic [POS_W-1:0]    pos;
    logic [4*DIGITS-1:0] act_data;
    logic [4*DIGITS-1:0] pend_data;
    logic [DIGITS-1:0]   act_mask;
    logic [DIGITS-1:0]   pend_mask;
    logic [DIGITS-1:0]   lz_blank;
    logic [DIGITS-1:0]   sel_onehot;
    logic [3:0]          cur_nib;
    logic                cur_mask;
    logic                cur_lz;
    logic                zero_run;
    logic                tick_wrap;
    logic                boundary;
    logic                duty_on;
    logic                lit;
    logic [6:0]          seg_d;
    logic [DIGITS-1:0]   an_d;
`ifdef SEG_SCAN_DP_EN
    logic [DIGITS-1:0]   act_dp;
    logic [DIGITS-1:0]   pend_dp;
    logic                cur_dp;
    logic                dp_d;
`endif

    assign tick_wrap = &tick;
    assign boundary  = tick_wrap && (pos == LAST_POS);
    assign duty_on   = tick[DIV_W-1 -: PWM_W] < brightness;

    // A digit is a leading zero when it and every digit to its left are zero; digit 0 never is.
    always_comb begin
        lz_blank = '0;
        zero_run = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run && (act_data[4*k +: 4] == 4'h0);
            if (k != 0) lz_blank[k] = lz_en && zero_run;
        end
    end

    always_comb begin
        cur_nib    = 4'h0;
        cur_mask   = 1'b0;
        cur_lz     = 1'b0;
        sel_onehot = '0;
`ifdef SEG_SCAN_DP_EN
        cur_dp     = 1'b0;
`endif
        for (int k = 0; k < DIGITS; k++) begin
            if (pos == POS_W'(k)) begin
                cur_nib       = act_data[4*k +: 4];
                cur_mask      = act_mask[k];
                cur_lz        = lz_blank[k];
                sel_onehot[k] = 1'b1;
`ifdef SEG_SCAN_DP_EN
                cur_dp        = act_dp[k];
`endif
            end
        end
`ifdef SEG_SCAN_DP_EN
        // A suppressed leading zero with its point set stays lit to show just the point.
        lit   = duty_on && !cur_mask && (!cur_lz || cur_dp);
        seg_d = !lit ? 7'h7F : (cur_lz ? 7'h7F : hex_to_seg(cur_nib));
        dp_d  = lit ? !cur_dp : 1'b1;
`else
        lit   = duty_on && !cur_mask && !cur_lz;
        seg_d = lit ? hex_to_seg(cur_nib) : 7'h7F;
`endif
        an_d = lit ? ~sel_onehot : '1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick <= '0;
            pos  <= '0;
        end else begin
            tick <= tick + 1'b1;
            if (tick_wrap) pos <= (pos == LAST_POS) ? '0 : pos + 1'b1;
        end
    end

    // Active frame only changes at a boundary so the scan never tears; a load landing on the
    // boundary itself bypasses the pending buffer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            act_data  <= '0;
            act_mask  <= '0;
            pend_data <= '0;
            pend_mask <= '0;
            pending   <= 1'b0;
`ifdef SEG_SCAN_DP_EN
            act_dp    <= '0;
            pend_dp   <= '0;
`endif
        end else if (boundary) begin
            if (load) begin
                act_data <= data;
                act_mask <= blank_mask;
`ifdef SEG_SCAN_DP_EN
                act_dp   <= dp_mask;
`endif
            end else if (pending) begin
                act_data <= pend_data;
                act_mask <= pend_mask;
`ifdef SEG_SCAN_DP_EN
                act_dp   <= pend_dp;
`endif
            end
            pending <= 1'b0;
        end else if (load) begin
            pend_data <= data;
            pend_mask <= blank_mask;
`ifdef SEG_SCAN_DP_EN
            pend_dp   <= dp_mask;
`endif
            pending   <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg        <= 7'h7F;
            an         <= '1;
            frame_done <= 1'b0;
`ifdef SEG_SCAN_DP_EN
            dp         <= 1'b1;
`endif
        end else begin
            seg        <= seg_d;
            an         <= an_d;
            frame_done <= boundary;
`ifdef SEG_SCAN_DP_EN
            dp         <= dp_d;
`endif
        end
    end

endmodule
